airlock_sequencer: RTL and testbench
====================================

Name: airlock_sequencer

Overview:
- Top-level controller for the airlock chamber datapath (evacuate/pressurize pump unit plus inner and outer door actuators).
- Arbitrates transit requests from the ship side (inner) and the space side (outer).
- For each granted request, runs the full door/evacuate/pressurize sequence, using handshakes with the chamber and timed door phases.
- Guarantees both doors are never open at once, and that no door opens against the wrong chamber pressure.

Parameters:
- DOOR_HOLD, 4, cycles a door stays open per phase (>=1)
- EVAC_TIMEOUT, 12, max cycles evac_cmd may wait for evac_ack before fault
- PRESS_TIMEOUT, 12, max cycles press_cmd may wait for press_ack before fault
- CNT_W, 8, phase counter width; every timing parameter must be < 2**CNT_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_inner  in  1  level request: occupant at inner door wants to go out (outbound)
- req_outer  in  1  level request: occupant at outer door wants to come in (inbound)
- evac_ack  in  1  chamber reports vacuum reached
- press_ack  in  1  chamber reports pressure reached
- grant_inner  out  1  one-cycle pulse: inner request accepted
- grant_outer  out  1  one-cycle pulse: outer request accepted
- evac_cmd  out  1  level: evacuate chamber, held until ack
- press_cmd  out  1  level: pressurize chamber, held until ack
- inner_open  out  1  inner door open
- outer_open  out  1  outer door open
- pressurized  out  1  chamber at pressure (status)
- evacuated  out  1  chamber at vacuum (status)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on return to an idle state
- fault  out  1  sticky ack-timeout fault

Behaviour:
- All outputs are registered.
- Reset: enter P_IDLE.
  - pressurized=1.
  - All other outputs 0.
  - Round-robin pointer set to favour inner.
  - Counter cleared.
  - Reset mid-sequence aborts immediately: doors close and cmds drop asynchronously.
- States: P_IDLE, E_IDLE, OPEN_INNER, OPEN_OUTER, EVAC, PRESS, FAULT.
- Requests are sampled only in P_IDLE/E_IDLE.
- Arbitration:
  - If only one request is high, it wins.
  - If both are high, the side not served last wins. Then the pointer flips.
- Acceptance timing: at the accepting edge, the state advances, grant_x=1 for exactly the following cycle, and busy=1.
  - A requester drops its request after grant.
  - A request still high back in idle is treated as a new transit.
- Outbound path (inner request): [PRESS if in E_IDLE] -> OPEN_INNER -> EVAC -> OPEN_OUTER -> E_IDLE.
- Inbound path (outer request): [EVAC if in P_IDLE] -> OPEN_OUTER -> PRESS -> OPEN_INNER -> P_IDLE.
- OPEN_INNER / OPEN_OUTER:
  - Door output =1 for exactly DOOR_HOLD cycles. The counter loads DOOR_HOLD-1 on entry.
  - The door closes in the same edge as the next-state transition.
- EVAC:
  - evac_cmd=1 from the entry cycle.
  - On the edge evac_ack=1 is sampled: evac_cmd->0, evacuated->1, advance.
  - If EVAC_TIMEOUT cycles elapse with no ack: FAULT.
  - pressurized->0 on EVAC entry. Both statuses are 0 while evacuating.
- PRESS: symmetric to EVAC, using press_cmd, press_ack, PRESS_TIMEOUT and pressurized. evacuated->0 on entry.
- An ack arriving on the same edge the timeout would expire counts as success.
- Acks outside the matching state are ignored.
- Invariants:
  - inner_open & outer_open is never 1.
  - inner_open only when pressurized=1.
  - outer_open only when evacuated=1.
  - evac_cmd & press_cmd is never 1.
  - Never both doors open while a cmd is high.
- done=1 for one cycle on entry to P_IDLE/E_IDLE from a sequence. busy=0 in that cycle.
- FAULT:
  - Doors closed, cmds 0, fault=1, busy=1.
  - Statuses hold their last values.
  - Requests are ignored. Only rst exits.
- Counter: saturating down-counter of CNT_W bits. Counter reaching 0 marks phase end or timeout.

Decomposition:
- airlock_pkg holds:
  - The state enum.
  - A direction constant (DIR_OUT/DIR_IN).
  - Default timing constants.
- One sub-module, phase_timer: loadable CNT_W down-counter with load, enable, and zero flag.
- The FSM, arbiter and output registers stay in airlock_sequencer.

Test Plan:
1. Reset, then req_inner=1 for 1 cycle in P_IDLE; evac_ack after 3 cycles in EVAC -> grant_inner pulse; inner_open high exactly 4 cycles; evac_cmd high 3 cycles; outer_open high 4 cycles; E_IDLE with evacuated=1; done pulse.
2. From E_IDLE, req_outer; press_ack after 5 cycles -> outer_open 4 cycles, press_cmd 5 cycles, inner_open 4 cycles; P_IDLE, pressurized=1.
3. req_inner and req_outer asserted together in P_IDLE, after reset -> grant_inner first. Keep req_outer high -> next grant_outer from E_IDLE, with no EVAC phase needed.
4. req_outer in P_IDLE -> EVAC precedes OPEN_OUTER; outer_open never high while pressurized=1.
5. EVAC with evac_ack never asserted -> fault=1 after 12 cycles, evac_cmd=0, doors closed. Later requests get no grant until rst.
6. rst pulsed while inner_open=1 -> inner_open=0 immediately (asynchronous); state P_IDLE, pressurized=1. Assertion check: no cycle has both doors open, across all runs.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared encodings and default timing for the airlock chamber controller.
// States are plain localparams so older tools and netlists can name them directly.
package airlock_pkg;

  typedef logic [2:0] state_t;

  localparam state_t P_IDLE     = 3'd0;
  localparam state_t E_IDLE     = 3'd1;
  localparam state_t OPEN_INNER = 3'd2;
  localparam state_t OPEN_OUTER = 3'd3;
  localparam state_t EVAC       = 3'd4;
  localparam state_t PRESS      = 3'd5;
  localparam state_t FAULT      = 3'd6;

  // Transit direction: outbound starts at the inner door, inbound at the outer door.
  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  localparam int DEF_DOOR_HOLD     = 4;
  localparam int DEF_EVAC_TIMEOUT  = 12;
  localparam int DEF_PRESS_TIMEOUT = 12;
  localparam int DEF_CNT_W         = 8;

  function automatic logic is_idle(input state_t s);
    return (s == P_IDLE) || (s == E_IDLE);
  endfunction

endpackage

// File: rtl/airlock_sequencer_phase_timer.sv
// Loadable saturating down-counter; zero marks the end of a door phase or an ack timeout.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber controller: arbitrates inner/outer transit requests and sequences
// doors, evacuation and pressurization so no door ever opens against the wrong pressure.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int DOOR_HOLD     = DEF_DOOR_HOLD,
  parameter int EVAC_TIMEOUT  = DEF_EVAC_TIMEOUT,
  parameter int PRESS_TIMEOUT = DEF_PRESS_TIMEOUT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic req_inner,
  input  logic req_outer,
  input  logic evac_ack,
  input  logic press_ack,
  output logic grant_inner,
  output logic grant_outer,
  output logic evac_cmd,
  output logic press_cmd,
  output logic inner_open,
  output logic outer_open,
  output logic pressurized,
  output logic evacuated,
  output logic busy,
  output logic done,
  output logic fault
);

  localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_HOLD - 1);
  localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_TIMEOUT - 1);

  state_t state_q, state_d;
  logic   dir_q, dir_d;
  logic   prio_inner_q, prio_inner_d;
  logic   grant_inner_q, grant_inner_d;
  logic   grant_outer_q, grant_outer_d;
  logic   evac_cmd_q, evac_cmd_d;
  logic   press_cmd_q, press_cmd_d;
  logic   inner_open_q, inner_open_d;
  logic   outer_open_q, outer_open_d;
  logic   pressurized_q, pressurized_d;
  logic   evacuated_q, evacuated_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   fault_q, fault_d;

  logic             take_inner, take_outer;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  // Arbitration and next-state; pointer always favours the side not served last.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    prio_inner_d  = prio_inner_q;
    grant_inner_d = 1'b0;
    grant_outer_d = 1'b0;
    take_inner    = 1'b0;
    take_outer    = 1'b0;
    case (state_q)
      P_IDLE, E_IDLE: begin
        if (req_inner && (!req_outer || prio_inner_q)) begin
          take_inner = 1'b1;
        end else if (req_outer) begin
          take_outer = 1'b1;
        end
        if (take_inner) begin
          dir_d         = DIR_OUT;
          prio_inner_d  = 1'b0;
          grant_inner_d = 1'b1;
          state_d       = (state_q == P_IDLE) ? OPEN_INNER : PRESS;
        end else if (take_outer) begin
          dir_d         = DIR_IN;
          prio_inner_d  = 1'b1;
          grant_outer_d = 1'b1;
          state_d       = (state_q == E_IDLE) ? OPEN_OUTER : EVAC;
        end
      end
      OPEN_INNER: if (tmr_zero) state_d = (dir_q == DIR_OUT) ? EVAC : P_IDLE;
      OPEN_OUTER: if (tmr_zero) state_d = (dir_q == DIR_OUT) ? E_IDLE : PRESS;
      EVAC: begin
        if (evac_ack) state_d = OPEN_OUTER;
        else if (tmr_zero) state_d = FAULT;
      end
      PRESS: begin
        if (press_ack) state_d = OPEN_INNER;
        else if (tmr_zero) state_d = FAULT;
      end
      default: state_d = FAULT;
    endcase
  end

  // Every phase entry reloads the timer; an ack on the expiring edge still wins above.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_en   = (state_q == OPEN_INNER) || (state_q == OPEN_OUTER) ||
               (state_q == EVAC) || (state_q == PRESS);
    case (state_d)
      EVAC:    tmr_val = EVAC_LOAD;
      PRESS:   tmr_val = PRESS_LOAD;
      default: tmr_val = DOOR_LOAD;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    pressurized_d = pressurized_q;
    evacuated_d   = evacuated_q;
    if ((state_q == EVAC) && evac_ack) evacuated_d = 1'b1;
    if ((state_q == PRESS) && press_ack) pressurized_d = 1'b1;
    if ((state_d != state_q) && ((state_d == EVAC) || (state_d == PRESS))) begin
      pressurized_d = 1'b0;
      evacuated_d   = 1'b0;
    end
    inner_open_d = (state_d == OPEN_INNER);
    outer_open_d = (state_d == OPEN_OUTER);
    evac_cmd_d   = (state_d == EVAC);
    press_cmd_d  = (state_d == PRESS);
    busy_d       = !is_idle(state_d);
    done_d       = !is_idle(state_q) && (state_q != FAULT) && is_idle(state_d);
    fault_d      = fault_q || (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= P_IDLE;
      dir_q         <= DIR_OUT;
      prio_inner_q  <= 1'b1;
      grant_inner_q <= 1'b0;
      grant_outer_q <= 1'b0;
      evac_cmd_q    <= 1'b0;
      press_cmd_q   <= 1'b0;
      inner_open_q  <= 1'b0;
      outer_open_q  <= 1'b0;
      pressurized_q <= 1'b1;
      evacuated_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      prio_inner_q  <= prio_inner_d;
      grant_inner_q <= grant_inner_d;
      grant_outer_q <= grant_outer_d;
      evac_cmd_q    <= evac_cmd_d;
      press_cmd_q   <= press_cmd_d;
      inner_open_q  <= inner_open_d;
      outer_open_q  <= outer_open_d;
      pressurized_q <= pressurized_d;
      evacuated_q   <= evacuated_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign grant_inner = grant_inner_q;
  assign grant_outer = grant_outer_q;
  assign evac_cmd    = evac_cmd_q;
  assign press_cmd   = press_cmd_q;
  assign inner_open  = inner_open_q;
  assign outer_open  = outer_open_q;
  assign pressurized = pressurized_q;
  assign evacuated   = evacuated_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: a chamber model answers cmds after a set latency and a
// scoreboard matches every output pulse (signal, length) against the expected sequence.
module tb_airlock_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_inner = 1'b0, req_outer = 1'b0;
  logic evac_ack = 1'b0, press_ack = 1'b0;
  logic grant_inner, grant_outer, evac_cmd, press_cmd;
  logic inner_open, outer_open, pressurized, evacuated, busy, done, fault;

  int total = 0;
  int bad = 0;

  // Pulse ids: 0 grant_inner, 1 grant_outer, 2 inner_open, 3 outer_open, 4 evac_cmd, 5 press_cmd, 6 done
  int exp_sig[$];
  int exp_len[$];
  int run[7];
  int evac_lat = 3, press_lat = 5;
  int evac_cnt = 0, press_cnt = 0;

  airlock_sequencer dut (
    .clk(clk), .rst(rst), .req_inner(req_inner), .req_outer(req_outer),
    .evac_ack(evac_ack), .press_ack(press_ack),
    .grant_inner(grant_inner), .grant_outer(grant_outer),
    .evac_cmd(evac_cmd), .press_cmd(press_cmd),
    .inner_open(inner_open), .outer_open(outer_open),
    .pressurized(pressurized), .evacuated(evacuated),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic string sig_name(input int s);
    case (s)
      0: return "grant_inner";
      1: return "grant_outer";
      2: return "inner_open";
      3: return "outer_open";
      4: return "evac_cmd";
      5: return "press_cmd";
      6: return "done";
      default: return "none";
    endcase
  endfunction

  task automatic push_ev(input int s, input int len);
    exp_sig.push_back(s);
    exp_len.push_back(len);
  endtask

  // Chamber model: ack raised in the lat-th cycle a cmd is held; lat 0 never acks.
  always @(negedge clk) begin
    if (evac_cmd) begin
      evac_cnt = evac_cnt + 1;
      evac_ack = (evac_lat != 0) && (evac_cnt == evac_lat);
    end else begin
      evac_cnt = 0;
      evac_ack = 1'b0;
    end
    if (press_cmd) begin
      press_cnt = press_cnt + 1;
      press_ack = (press_lat != 0) && (press_cnt == press_lat);
    end else begin
      press_cnt = 0;
      press_ack = 1'b0;
    end
  end

  // Scoreboard: each completed pulse is popped against the queue; safety invariants every cycle.
  always @(negedge clk) begin
    logic [6:0] obs;
    int s, l;
    obs = {done, press_cmd, evac_cmd, outer_open, inner_open, grant_outer, grant_inner};
    if (rst) begin
      for (int i = 0; i < 7; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (obs[i]) begin
          run[i] = run[i] + 1;
        end else if (run[i] > 0) begin
          total++;
          if (exp_sig.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_pulse: got %s len=%0d, expected no pulse", sig_name(i), run[i]);
          end else begin
            s = exp_sig.pop_front();
            l = exp_len.pop_front();
            if (s != i || l != run[i]) begin
              bad++;
              $display("[TB] FAIL pulse_seq: got %s len=%0d, expected %s len=%0d",
                       sig_name(i), run[i], sig_name(s), l);
            end
          end
          run[i] = 0;
        end
      end
      total++;
      if ((inner_open && outer_open) || (inner_open && !pressurized) ||
          (outer_open && !evacuated) || (evac_cmd && press_cmd)) begin
        bad++;
        $display("[TB] FAIL safety @%0t: inner=%b outer=%b press=%b evac=%b ecmd=%b pcmd=%b, expected safe combination",
                 $time, inner_open, outer_open, pressurized, evacuated, evac_cmd, press_cmd);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_inner = 1'b0;
    req_outer = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic pulse_inner();
    @(posedge clk); #1 req_inner = 1'b1;
    @(posedge clk); #1 req_inner = 1'b0;
  endtask

  task automatic pulse_outer();
    @(posedge clk); #1 req_outer = 1'b1;
    @(posedge clk); #1 req_outer = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain_check(input string tag);
    @(negedge clk);
    @(posedge clk);
    total++;
    if (exp_sig.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_pending: %0d pulses still outstanding, expected 0 (next %s)",
               tag, exp_sig.size(), sig_name(exp_sig[0]));
    end
  endtask

  task automatic test_reset();
    logic [10:0] got;
    do_reset();
    @(negedge clk);
    got = {grant_inner, grant_outer, evac_cmd, press_cmd, inner_open, outer_open,
           pressurized, evacuated, busy, done, fault};
    total++;
    if (got !== 11'b00000010000) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b, expected %b", got, 11'b00000010000);
    end
  endtask

  task automatic test_outbound();
    bit ok;
    evac_lat = 3;
    push_ev(0, 1); push_ev(2, 4); push_ev(4, 3); push_ev(3, 4); push_ev(6, 1);
    pulse_inner();
    wait_done(60, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL outbound_done: got timeout, expected done pulse"); end
    total++;
    if ({evacuated, pressurized, busy} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL outbound_status: got evac/press/busy=%b, expected 100", {evacuated, pressurized, busy});
    end
    drain_check("outbound");
  endtask

  task automatic test_inbound();
    bit ok;
    press_lat = 5;
    push_ev(1, 1); push_ev(3, 4); push_ev(5, 5); push_ev(2, 4); push_ev(6, 1);
    pulse_outer();
    wait_done(60, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL inbound_done: got timeout, expected done pulse"); end
    total++;
    if ({evacuated, pressurized, busy} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL inbound_status: got evac/press/busy=%b, expected 010", {evacuated, pressurized, busy});
    end
    drain_check("inbound");
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    do_reset();
    evac_lat = 4;
    press_lat = 3;
    push_ev(0, 1); push_ev(2, 4); push_ev(4, 4); push_ev(3, 4); push_ev(6, 1);
    push_ev(1, 1); push_ev(3, 4); push_ev(5, 3); push_ev(2, 4); push_ev(6, 1);
    @(posedge clk); #1 req_inner = 1'b1; req_outer = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (grant_inner || grant_outer) begin
        seen = 1'b1;
        total++;
        if ({grant_inner, grant_outer} !== 2'b10) begin
          bad++;
          $display("[TB] FAIL rr_first: got inner/outer grant=%b, expected 10", {grant_inner, grant_outer});
        end
      end
    end
    req_inner = 1'b0;
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL rr_first_wait: got timeout, expected a grant"); end
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      if (grant_outer) begin
        seen = 1'b1;
        total++;
        if ({outer_open, evacuated, evac_cmd} !== 3'b110) begin
          bad++;
          $display("[TB] FAIL rr_second_direct: got outer_open/evacuated/evac_cmd=%b, expected 110",
                   {outer_open, evacuated, evac_cmd});
        end
      end
    end
    req_outer = 1'b0;
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL rr_second_wait: got timeout, expected grant_outer"); end
    wait_done(60, ok);
    total++;
    if (!ok || !pressurized) begin
      bad++;
      $display("[TB] FAIL rr_end: got done_seen=%b pressurized=%b, expected 1 1", ok, pressurized);
    end
    drain_check("back_to_back");
  endtask

  task automatic test_inbound_from_pressure();
    bit ok;
    evac_lat = 6;
    press_lat = 7;
    push_ev(1, 1); push_ev(4, 6); push_ev(3, 4); push_ev(5, 7); push_ev(2, 4); push_ev(6, 1);
    pulse_outer();
    wait_done(80, ok);
    total++;
    if (!ok || {evacuated, pressurized} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL inbound_evac_first: got done_seen=%b evac/press=%b, expected 1 01",
               ok, {evacuated, pressurized});
    end
    drain_check("inbound_evac_first");
  endtask

  task automatic test_timeout_fault();
    bit seen;
    int grants;
    evac_lat = 0;
    push_ev(0, 1); push_ev(2, 4); push_ev(4, 12);
    pulse_inner();
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (fault) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL fault_wait: got timeout, expected fault"); end
    total++;
    if ({evac_cmd, press_cmd, inner_open, outer_open, busy, pressurized, evacuated} !== 7'b0000100) begin
      bad++;
      $display("[TB] FAIL fault_outputs: got ecmd/pcmd/in/out/busy/press/evac=%b, expected 0000100",
               {evac_cmd, press_cmd, inner_open, outer_open, busy, pressurized, evacuated});
    end
    @(posedge clk); #1 req_inner = 1'b1; req_outer = 1'b1;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant_inner || grant_outer) grants++;
    end
    req_inner = 1'b0;
    req_outer = 1'b0;
    total++;
    if (grants != 0 || !fault) begin
      bad++;
      $display("[TB] FAIL fault_sticky: got grants=%0d fault=%b, expected 0 1", grants, fault);
    end
    drain_check("fault");
  endtask

  task automatic test_async_reset();
    bit ok;
    int opened;
    do_reset();
    @(negedge clk);
    total++;
    if ({fault, pressurized} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL fault_cleared: got fault/pressurized=%b, expected 01", {fault, pressurized});
    end
    push_ev(0, 1);
    pulse_inner();
    opened = 0;
    for (int c = 0; c < 20 && opened < 2; c++) begin
      @(negedge clk);
      if (inner_open) opened++;
    end
    total++;
    if (opened != 2) begin bad++; $display("[TB] FAIL async_open_wait: got %0d open cycles, expected 2", opened); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({inner_open, outer_open, evac_cmd, press_cmd, pressurized, busy} !== 6'b000010) begin
      bad++;
      $display("[TB] FAIL async_reset: got in/out/ecmd/pcmd/press/busy=%b, expected 000010",
               {inner_open, outer_open, evac_cmd, press_cmd, pressurized, busy});
    end
    @(negedge clk);
    #2 rst = 1'b0;
    evac_lat = 2;
    push_ev(0, 1); push_ev(2, 4); push_ev(4, 2); push_ev(3, 4); push_ev(6, 1);
    pulse_inner();
    wait_done(60, ok);
    total++;
    if (!ok || !evacuated) begin
      bad++;
      $display("[TB] FAIL post_reset_idle: got done_seen=%b evacuated=%b, expected 1 1", ok, evacuated);
    end
    drain_check("post_reset");
  endtask

  initial begin
    test_reset();
    test_outbound();
    test_inbound();
    test_back_to_back();
    test_inbound_from_pressure();
    test_timeout_fault();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected end of tests", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
